// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of an external combinational 4-bit ALU, with a
// registered result stage drained through a valid/ready handshake.
module alu_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  input  logic [1:0]               cmd_op,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [1:0]               alu_sel,
  input  logic [3:0]               alu_y,
  input  logic                     alu_cout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_y,
  output logic                     res_cout,
  output logic [1:0]               res_op,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  cmd_t           mem_q [DEPTH];
  logic [PW-1:0]  wrPtr_q, wrPtr_d;
  logic [PW-1:0]  rdPtr_q, rdPtr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           resValid_q, resValid_d;
  logic [3:0]     resY_q, resY_d;
  logic           resCout_q, resCout_d;
  logic [1:0]     resOp_q, resOp_d;

  logic           full;
  logic           empty;
  logic           push;
  logic           issue;
  cmd_t           head;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;
  assign issue = !empty && (!resValid_q || res_ready);
  assign head  = mem_q[rdPtr_q];

  // Storage is never reset; entries only become visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (issue) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    case ({push, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Carry out of the ALU is meaningless for logic ops, so it is masked here.
  always_comb begin
    resValid_d = resValid_q;
    resY_d     = resY_q;
    resCout_d  = resCout_q;
    resOp_d    = resOp_q;
    if (issue) begin
      resValid_d = 1'b1;
      resY_d     = alu_y;
      resCout_d  = alu_sel[1] ? 1'b0 : alu_cout;
      resOp_d    = alu_sel;
    end else if (resValid_q && res_ready) begin
      resValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      resValid_q <= 1'b0;
      resY_q     <= '0;
      resCout_q  <= 1'b0;
      resOp_q    <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      resValid_q <= resValid_d;
      resY_q     <= resY_d;
      resCout_q  <= resCout_d;
      resOp_q    <= resOp_d;
    end
  end

  assign cmd_ready = !full;
  assign alu_a     = empty ? 4'd0 : head.a;
  assign alu_b     = empty ? 4'd0 : head.b;
  assign alu_sel   = empty ? 2'd0 : head.op;
  assign res_valid = resValid_q;
  assign res_y     = resY_q;
  assign res_cout  = resCout_q;
  assign res_op    = resOp_q;
  assign count     = count_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed and randomised checks of alu_cmd_queue with a behavioural ALU
// attached to its alu_* ports.
module tb_alu_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_y;
  logic       alu_cout;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_y;
  logic       res_cout;
  logic [1:0] res_op;
  logic [2:0] count;

  int compareCount;
  int mismatchCount;

  alu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .alu_cout  (alu_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_cout  (res_cout),
    .res_op    (res_op),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; drives cout high on logic ops so masking in the DUT is visible.
  always_comb begin
    alu_y    = 4'd0;
    alu_cout = 1'b0;
    case (alu_sel)
      2'b00: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: {alu_cout, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10: begin alu_y = alu_a & alu_b; alu_cout = 1'b1; end
      default: begin alu_y = alu_a | alu_b; alu_cout = 1'b1; end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] a,
                               input logic [3:0] b, input logic [1:0] op);
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
  endtask

  task automatic checkResult(input string tag, input logic [3:0] y,
                             input logic c, input logic [1:0] op);
    checkOutput({tag, ".valid"}, res_valid, 1);
    checkOutput({tag, ".y"}, res_y, y);
    checkOutput({tag, ".cout"}, res_cout, c);
    checkOutput({tag, ".op"}, res_op, op);
  endtask

  function automatic logic [4:0] expRes(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  logic [3:0] fullA [6] = '{4'd1, 4'd15, 4'd0, 4'd6, 4'd5, 4'd7};
  logic [3:0] fullB [6] = '{4'd2, 4'd1, 4'd1, 4'd3, 4'd10, 4'd7};
  logic [1:0] fullOp [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
  logic [3:0] fullY [5] = '{4'h3, 4'h0, 4'hF, 4'h2, 4'hF};
  logic       fullC [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  // Random phase: model of FIFO contents and the result register.
  logic [9:0] modelQ [$];
  logic       mResValid;
  logic [6:0] mRes;
  int         sent;
  int         consumed;

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n     = 1'b0;
    res_ready = 1'b0;
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst.count", count, 0);
    checkOutput("rst.res_valid", res_valid, 0);
    checkOutput("rst.cmd_ready", cmd_ready, 1);
    checkOutput("rst.alu_a", alu_a, 0);
    checkOutput("rst.res_y", res_y, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single add: 9 + 8 = 0x11
    res_ready = 1'b1;
    applyStimulus(1, 4'd9, 4'd8, 2'b00);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    checkOutput("add.count", count, 1);
    checkOutput("add.alu_a", alu_a, 9);
    checkOutput("add.alu_b", alu_b, 8);
    checkOutput("add.res_valid_early", res_valid, 0);
    @(negedge clk);
    checkResult("add", 4'h1, 1'b1, 2'b00);
    checkOutput("add.count_after", count, 0);
    @(negedge clk);
    checkOutput("add.drained", res_valid, 0);
    checkOutput("add.y_hold", res_y, 1);

    // Back-to-back sub/and/or
    applyStimulus(1, 4'd3, 4'd5, 2'b01);
    @(negedge clk);
    applyStimulus(1, 4'd12, 4'd10, 2'b10);
    @(negedge clk);
    checkResult("sub", 4'hE, 1'b1, 2'b01);
    applyStimulus(1, 4'd12, 4'd10, 2'b11);
    @(negedge clk);
    checkResult("and", 4'h8, 1'b0, 2'b10);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkResult("or", 4'hE, 1'b0, 2'b11);
    @(negedge clk);
    checkOutput("b2b.drained", res_valid, 0);

    // Fill with result path blocked
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, fullA[i], fullB[i], fullOp[i]);
      @(negedge clk);
    end
    applyStimulus(1, fullA[5], fullB[5], fullOp[5]);
    checkOutput("full.count", count, 4);
    checkOutput("full.cmd_ready", cmd_ready, 0);
    checkResult("full.head", fullY[0], fullC[0], fullOp[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold.count", count, 4);
      checkOutput("hold.y", res_y, fullY[0]);
      checkOutput("hold.op", res_op, fullOp[0]);
      checkOutput("hold.cmd_ready", cmd_ready, 0);
    end
    res_ready = 1'b1;
    checkResult("drain0", fullY[0], fullC[0], fullOp[0]);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    checkOutput("full.no_passthru", count, 3);
    checkResult("drain1", fullY[1], fullC[1], fullOp[1]);
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      checkResult("drainN", fullY[i], fullC[i], fullOp[i]);
    end
    @(negedge clk);
    checkOutput("full.empty_valid", res_valid, 0);
    checkOutput("full.empty_count", count, 0);
    checkOutput("empty.alu_a", alu_a, 0);
    checkOutput("empty.alu_b", alu_b, 0);
    checkOutput("empty.alu_sel", alu_sel, 0);

    // Mid-stream asynchronous reset with three entries queued
    res_ready = 1'b0;
    for (int i = 2; i < 6; i++) begin
      applyStimulus(1, 4'(i), 4'(i), 2'b00);
      @(negedge clk);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("mid.count_pre", count, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("mid.count", count, 0);
    checkOutput("mid.res_valid", res_valid, 0);
    checkOutput("mid.res_y", res_y, 0);
    checkOutput("mid.cmd_ready", cmd_ready, 1);
    checkOutput("mid.alu", {alu_a, alu_b, alu_sel}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid.post_count", count, 0);
    checkOutput("mid.post_valid", res_valid, 0);

    // Random traffic against the model
    mResValid = 1'b0;
    mRes      = '0;
    sent      = 0;
    consumed  = 0;
    for (int cyc = 0; cyc < 1000 && consumed < 20; cyc++) begin
      logic pushNow;
      logic issueNow;
      logic [9:0] c;
      checkOutput("rnd.count", count, modelQ.size());
      checkOutput("rnd.cmd_ready", cmd_ready, modelQ.size() < DEPTH);
      checkOutput("rnd.res_valid", res_valid, mResValid);
      if (mResValid) begin
        checkOutput("rnd.result", {res_op, res_cout, res_y}, mRes);
      end
      c = 10'($urandom);
      applyStimulus((sent < 20) && ($urandom_range(0, 3) != 0), c[9:6], c[5:2], c[1:0]);
      res_ready = ($urandom_range(0, 2) != 0);
      pushNow  = cmd_valid && (modelQ.size() < DEPTH);
      issueNow = (modelQ.size() > 0) && (!mResValid || res_ready);
      if (mResValid && res_ready) consumed++;
      if (issueNow) begin
        logic [9:0] h;
        h = modelQ.pop_front();
        mRes = {h[1:0], expRes(h[9:6], h[5:2], h[1:0])};
        mResValid = 1'b1;
      end else if (res_ready) begin
        mResValid = 1'b0;
      end
      if (pushNow) begin
        modelQ.push_back(c);
        sent++;
      end
      @(negedge clk);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("rnd.consumed", consumed, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
